rotate_exec: RTL and testbench

Sequenced execution unit for the 4-bit RLC r / RRC r instructions of the E0C6S46-style core. It accepts one rotate request from the instruction decoder and fetches the operand from A, B, M(X) or M(Y). It computes the rotate through carry, then writes back the result, carry and zero flags with the instruction's native cycle length. It sits between the decoder/sequencer and the register file / data RAM port.

---
 rtl/rotate_exec.sv | 202 ++++++++++++++++++++
 tb/tb_rotate_exec.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rotate_exec.sv
// rotate_exec: sequenced RLC r / RRC r execution unit (4-bit rotate through carry).
// Latency: RRC 5 cycles, RLC 7 cycles (ROTATE_EXACT_TIMING_EN defined); otherwise 5 (RAM operand) / 4 (A/B operand).
// Backpressure: none; start is sampled only in IDLE and ignored while busy, RAM read data is fixed 1-cycle latency.
//
// Configuration macro: ROTATE_EXACT_TIMING_EN
//   defined   -> native instruction timing (FETCH always visited, two WAIT cycles for RLC)
//   undefined -> shortened timing (no WAIT, FETCH skipped for register operands)
//
// Ports:
//   clk, reset                  core clock, synchronous active-high reset
//   start, op_rrc, r, carry_in  request from decoder (r: 0=A 1=B 2=M(X) 3=M(Y); op_rrc: 0=RLC 1=RRC)
//   a_in, b_in, x_in, y_in      current register values
//   ram_rdata                   RAM read data, valid the cycle after ram_re
//   busy, done                  status; done is a one-cycle pulse in the WRITE cycle
//   ram_addr/re/we/wdata        data RAM port
//   a_we, b_we, result          register write-back
//   flag_we, carry_out, zero_out  flag write-back

module rotate_exec (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        op_rrc,
    input  logic [1:0]  r,
    input  logic        carry_in,
    input  logic [3:0]  a_in,
    input  logic [3:0]  b_in,
    input  logic [11:0] x_in,
    input  logic [11:0] y_in,
    input  logic [3:0]  ram_rdata,
    output logic        busy,
    output logic        done,
    output logic [11:0] ram_addr,
    output logic        ram_re,
    output logic        ram_we,
    output logic [3:0]  ram_wdata,
    output logic        a_we,
    output logic        b_we,
    output logic [3:0]  result,
    output logic        flag_we,
    output logic        carry_out,
    output logic        zero_out
);

`ifdef ROTATE_EXACT_TIMING_EN
    localparam bit EXACT_TIMING = 1'b1;
`else
    localparam bit EXACT_TIMING = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_CAPTURE,
        S_EXEC,
        S_WAIT,
        S_WRITE
    } state_t;

    state_t      state_q, state_d;
    logic        wait_q, wait_d;

    // Request fields captured at start
    logic        op_q;
    logic [1:0]  r_q;
    logic        cin_q;
    logic [3:0]  a_q;
    logic [3:0]  b_q;
    logic [11:0] addr_q;
    logic [3:0]  operand_q;

    // Registered outputs
    logic        busy_q, done_q, ram_re_q, ram_we_q, a_we_q, b_we_q, flag_we_q;
    logic [3:0]  result_q, wdata_q;
    logic        carry_q, zero_q;

    // Rotate datapath
    logic [3:0]  rot_res;
    logic        rot_cy;

    logic        accept;
    logic        enter_write;

    assign accept      = (state_q == S_IDLE) && start;
    assign enter_write = (state_d == S_WRITE);

    always_comb begin
        rot_res = 4'd0;
        rot_cy  = 1'b0;
        if (op_q) begin
            {rot_res, rot_cy} = {cin_q, operand_q};
        end else begin
            {rot_cy, rot_res} = {operand_q, cin_q};
        end
    end

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    // Register operands need no RAM access, so the shortened build skips FETCH
                    state_d = (EXACT_TIMING || r[1]) ? S_FETCH : S_CAPTURE;
                end
            end
            S_FETCH:   state_d = S_CAPTURE;
            S_CAPTURE: state_d = S_EXEC;
            S_EXEC: begin
                if (EXACT_TIMING && !op_q) begin
                    state_d = S_WAIT;
                    wait_d  = 1'b0;
                end else begin
                    state_d = S_WRITE;
                end
            end
            S_WAIT: begin
                // Two pad cycles: wait_q=0 on the first, 1 on the second
                if (wait_q) begin
                    state_d = S_WRITE;
                end else begin
                    wait_d = 1'b1;
                end
            end
            S_WRITE:   state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            wait_q    <= 1'b0;
            op_q      <= 1'b0;
            r_q       <= 2'd0;
            cin_q     <= 1'b0;
            a_q       <= 4'd0;
            b_q       <= 4'd0;
            addr_q    <= 12'd0;
            operand_q <= 4'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ram_re_q  <= 1'b0;
            ram_we_q  <= 1'b0;
            a_we_q    <= 1'b0;
            b_we_q    <= 1'b0;
            flag_we_q <= 1'b0;
            result_q  <= 4'd0;
            wdata_q   <= 4'd0;
            carry_q   <= 1'b0;
            zero_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;

            if (accept) begin
                op_q   <= op_rrc;
                r_q    <= r;
                cin_q  <= carry_in;
                a_q    <= a_in;
                b_q    <= b_in;
                addr_q <= r[1] ? (r[0] ? y_in : x_in) : 12'd0;
            end

            if (state_q == S_CAPTURE) begin
                operand_q <= r_q[1] ? ram_rdata : (r_q[0] ? b_q : a_q);
            end

            if (state_q == S_EXEC) begin
                result_q <= rot_res;
                wdata_q  <= rot_res;
                carry_q  <= rot_cy;
                zero_q   <= (rot_res == 4'd0);
            end

            // Strobes are computed from the next state so they are flop outputs
            busy_q    <= (state_d != S_IDLE);
            ram_re_q  <= accept && r[1];
            done_q    <= enter_write;
            flag_we_q <= enter_write;
            a_we_q    <= enter_write && (r_q == 2'd0);
            b_we_q    <= enter_write && (r_q == 2'd1);
            ram_we_q  <= enter_write && r_q[1];
        end
    end

    // Gate completion/write strobes with reset so a reset landing on the WRITE
    // cycle still suppresses the write-back.
    assign busy      = busy_q;
    assign done      = done_q    & ~reset;
    assign flag_we   = flag_we_q & ~reset;
    assign a_we      = a_we_q    & ~reset;
    assign b_we      = b_we_q    & ~reset;
    assign ram_we    = ram_we_q  & ~reset;
    assign ram_re    = ram_re_q;
    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;
    assign result    = result_q;
    assign carry_out = carry_q;
    assign zero_out  = zero_q;

endmodule

// File: tb/tb_rotate_exec.sv
// tb_rotate_exec: randomized and directed self-checking bench for rotate_exec.
// Latency: drives one request at a time, optionally back-to-back in the cycle after WRITE.
// Backpressure: none; the bench models A/B registers and a 4K x 4 RAM with 1-cycle read latency.

module tb_rotate_exec;

`ifdef ROTATE_EXACT_TIMING_EN
    localparam bit EXACT = 1'b1;
`else
    localparam bit EXACT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        op_rrc;
    logic [1:0]  r;
    logic        carry_in;
    logic [3:0]  a_in, b_in;
    logic [11:0] x_in, y_in;
    logic [3:0]  ram_rdata;
    logic        busy, done;
    logic [11:0] ram_addr;
    logic        ram_re, ram_we;
    logic [3:0]  ram_wdata;
    logic        a_we, b_we;
    logic [3:0]  result;
    logic        flag_we, carry_out, zero_out;

    int checks   = 0;
    int failures = 0;

    logic [3:0] mem [0:4095];
    logic [3:0] a_reg, b_reg;

    always #5 clk = ~clk;

    rotate_exec dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op_rrc    (op_rrc),
        .r         (r),
        .carry_in  (carry_in),
        .a_in      (a_in),
        .b_in      (b_in),
        .x_in      (x_in),
        .y_in      (y_in),
        .ram_rdata (ram_rdata),
        .busy      (busy),
        .done      (done),
        .ram_addr  (ram_addr),
        .ram_re    (ram_re),
        .ram_we    (ram_we),
        .ram_wdata (ram_wdata),
        .a_we      (a_we),
        .b_we      (b_we),
        .result    (result),
        .flag_we   (flag_we),
        .carry_out (carry_out),
        .zero_out  (zero_out)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Run one request. reset_cyc/restart_cyc (0 = none) pulse reset/start in that cycle;
    // tail = extra cycles observed after done before returning.
    task automatic run_op(input string tag, input bit op, input logic [1:0] rr, input bit cin,
                          input logic [3:0] av, input logic [3:0] bv,
                          input logic [11:0] xv, input logic [11:0] yv,
                          input int reset_cyc, input int restart_cyc, input int tail);
        int         operand, t, eres, ecar, ezero, elat, budget;
        int         done_cyc, done_cnt, re_cnt, re_cyc, we_cnt, we_cyc, a_cnt, b_cnt, fl_cnt;
        logic [11:0] re_addr, we_addr, sel_addr;
        logic [3:0] memx0, memy0, rd_pend;
        logic       rd_vld, fl_c, fl_z, broke;
        logic       busy_h [0:31];

        a_reg = av;
        b_reg = bv;
        memx0 = mem[xv];
        memy0 = mem[yv];
        sel_addr = rr[0] ? yv : xv;
        case (rr)
            2'd0:    operand = int'(av);
            2'd1:    operand = int'(bv);
            2'd2:    operand = int'(mem[xv]);
            default: operand = int'(mem[yv]);
        endcase
        if (op) begin
            t    = int'(cin) * 16 + operand;
            eres = t / 2;
            ecar = t % 2;
        end else begin
            t    = operand * 2 + int'(cin);
            eres = t % 16;
            ecar = t / 16;
        end
        ezero = (eres == 0) ? 1 : 0;
        if (EXACT) elat = op ? 5 : 7;
        else       elat = (rr >= 2) ? 5 : 4;
        budget = (reset_cyc != 0) ? 12 : 20;

        done_cyc = 0; done_cnt = 0; re_cnt = 0; re_cyc = 0; we_cnt = 0; we_cyc = 0;
        a_cnt = 0; b_cnt = 0; fl_cnt = 0; re_addr = 0; we_addr = 0;
        rd_vld = 0; rd_pend = 0; fl_c = 0; fl_z = 0; broke = 0;
        for (int i = 0; i < 32; i++) busy_h[i] = 1'b0;

        start = 1'b1; op_rrc = op; r = rr; carry_in = cin;
        a_in = av; b_in = bv; x_in = xv; y_in = yv;

        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            busy_h[c] = busy;
            if (ram_re) begin
                re_cnt++; re_cyc = c; re_addr = ram_addr;
                rd_pend = mem[ram_addr]; rd_vld = 1'b1;
            end else begin
                rd_vld = 1'b0;
            end
            if (ram_we) begin
                we_cnt++; we_cyc = c; we_addr = ram_addr;
                mem[ram_addr] = ram_wdata;
            end
            if (a_we) begin a_cnt++; a_reg = result; end
            if (b_we) begin b_cnt++; b_reg = result; end
            if (flag_we) begin fl_cnt++; fl_c = carry_out; fl_z = zero_out; end
            if (done) begin
                done_cnt++;
                if (done_cyc == 0) done_cyc = c;
            end
            if (done_cyc != 0 && c >= done_cyc + tail) begin
                broke = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
            start = (c + 1 == restart_cyc);
            reset = (c + 1 == reset_cyc);
            // Request inputs are scrambled after cycle 1: the unit must use its latched copies
            op_rrc = 1'($urandom); r = 2'($urandom); carry_in = 1'($urandom);
            a_in = 4'($urandom); b_in = 4'($urandom);
            x_in = 12'($urandom); y_in = 12'($urandom);
            ram_rdata = rd_vld ? rd_pend : 4'($urandom);
        end
        if (broke) begin
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        reset = 1'b0;

        check({tag, ".busy_c1"}, busy_h[1], 1'b0);
        if (reset_cyc == 0) begin
            check({tag, ".busy_c2"}, busy_h[2], 1'b1);
            check({tag, ".done_cyc"}, done_cyc, elat);
            check({tag, ".done_cnt"}, done_cnt, 1);
            if (done_cyc > 0 && done_cyc < 31) begin
                check({tag, ".busy_done"}, busy_h[done_cyc], 1'b1);
                if (tail > 0) check({tag, ".busy_after"}, busy_h[done_cyc + 1], 1'b0);
            end
            check({tag, ".flag_cnt"}, fl_cnt, 1);
            check({tag, ".carry"}, fl_c, ecar);
            check({tag, ".zero"}, fl_z, ezero);
            check({tag, ".a_we_cnt"}, a_cnt, (rr == 2'd0));
            check({tag, ".b_we_cnt"}, b_cnt, (rr == 2'd1));
            check({tag, ".ram_we_cnt"}, we_cnt, rr[1]);
            check({tag, ".ram_re_cnt"}, re_cnt, rr[1]);
            if (rr[1]) begin
                check({tag, ".re_cyc"}, re_cyc, 2);
                check({tag, ".re_addr"}, re_addr, sel_addr);
                check({tag, ".we_cyc"}, we_cyc, elat);
                check({tag, ".we_addr"}, we_addr, sel_addr);
            end
            check({tag, ".A"}, a_reg, (rr == 2'd0) ? 4'(eres) : av);
            check({tag, ".B"}, b_reg, (rr == 2'd1) ? 4'(eres) : bv);
            check({tag, ".MX"}, mem[xv], (rr == 2'd2) ? 4'(eres) : memx0);
            check({tag, ".MY"}, mem[yv], (rr == 2'd3) ? 4'(eres) : memy0);
        end else begin
            check({tag, ".done_cnt"}, done_cnt, 0);
            check({tag, ".writes"}, a_cnt + b_cnt + we_cnt + fl_cnt, 0);
            check({tag, ".busy_after_rst"}, busy_h[reset_cyc + 1], 1'b0);
            check({tag, ".A"}, a_reg, av);
            check({tag, ".B"}, b_reg, bv);
            check({tag, ".MX"}, mem[xv], memx0);
            check({tag, ".MY"}, mem[yv], memy0);
        end
    endtask

    initial begin
        logic [11:0] xv, yv;

        reset = 1'b1; start = 1'b0; op_rrc = 1'b0; r = 2'd0; carry_in = 1'b0;
        a_in = 4'd0; b_in = 4'd0; x_in = 12'd0; y_in = 12'd0; ram_rdata = 4'd0;
        for (int i = 0; i < 4096; i++) mem[i] = 4'($urandom);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst.busy", busy, 1'b0);
        check("rst.done", done, 1'b0);
        check("rst.ram_re", ram_re, 1'b0);
        check("rst.ram_we", ram_we, 1'b0);
        check("rst.a_we", a_we, 1'b0);
        check("rst.b_we", b_we, 1'b0);
        check("rst.flag_we", flag_we, 1'b0);
        check("rst.carry", carry_out, 1'b0);
        check("rst.zero", zero_out, 1'b0);
        check("rst.ram_addr", ram_addr, 12'd0);
        check("rst.ram_wdata", ram_wdata, 4'd0);
        check("rst.result", result, 4'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Directed cases
        mem[12'h123] = 4'h7;
        mem[12'h456] = 4'h4;
        run_op("rlc_a",  1'b0, 2'd0, 1'b1, 4'h1, 4'h5, 12'h123, 12'h456, 0, 0, 1);
        run_op("rrc_b",  1'b1, 2'd1, 1'b0, 4'h3, 4'h8, 12'h123, 12'h456, 0, 0, 1);
        run_op("rrc_mx", 1'b1, 2'd2, 1'b1, 4'h3, 4'h8, 12'h123, 12'h456, 0, 0, 1);
        mem[12'h456] = 4'h8;
        run_op("rlc_my", 1'b0, 2'd3, 1'b0, 4'h3, 4'h8, 12'h123, 12'h456, 0, 0, 1);
        run_op("rst_mid", 1'b0, 2'd0, 1'b1, 4'h9, 4'h2, 12'h123, 12'h456, 4, 0, 0);
        run_op("fresh",   1'b0, 2'd0, 1'b1, 4'h9, 4'h2, 12'h123, 12'h456, 0, 0, 1);
        run_op("restart", 1'b1, 2'd0, 1'b0, 4'h6, 4'h2, 12'h123, 12'h456, 0, 3, 8);
        run_op("zero_rrc", 1'b1, 2'd1, 1'b0, 4'hC, 4'h1, 12'h123, 12'h456, 0, 0, 1);

        // Randomized, mostly back-to-back
        for (int n = 0; n < 40; n++) begin
            xv = 12'($urandom);
            yv = 12'($urandom);
            if (yv == xv) yv = xv ^ 12'h001;
            run_op($sformatf("rnd%0d", n), 1'($urandom), 2'($urandom), 1'($urandom),
                   4'($urandom), 4'($urandom), xv, yv, 0, 0, (n % 5 == 0) ? 2 : 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
